// File: rtl/clk_freq_meter_pkg.sv
// ----------------------------------------------------------------------------
// clk_freq_meter_pkg
// Shared definitions for the gated-window clock frequency meter.
//   - FSM state encoding (3-bit) for the sys_clk controller
//   - GATE_1MS: one-millisecond gate at a 50 MHz sys_clk, giving a kHz readout
//   - max_int: helper used to size the shared window/timeout counter
// ----------------------------------------------------------------------------
package clk_freq_meter_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_GATE      = 3'd1;
   localparam state_t ST_WAIT_DONE = 3'd2;
   localparam state_t ST_REPORT    = 3'd3;
   localparam state_t ST_DRAIN     = 3'd4;

   localparam int GATE_1MS = 50000;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/cdc_sync2.sv
// ----------------------------------------------------------------------------
// cdc_sync2
// Two-flop synchronizer, W bits wide, with asynchronous active-low reset.
// Also used as a reset-release synchronizer by tying d to 1.
// Ports:
//   clk    in   destination clock
//   rst_n  in   asynchronous active-low reset (clears both stages)
//   d      in   W-bit asynchronous input
//   q      out  W-bit synchronized output (2 clk latency)
// ----------------------------------------------------------------------------
module cdc_sync2 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_reg <= '0;
         q        <= '0;
      end else begin
         meta_reg <= d;
         q        <= meta_reg;
      end
   end

endmodule

// File: rtl/clk_freq_meter.sv
// ----------------------------------------------------------------------------
// clk_freq_meter
// Counts rising edges of clk_test over a window of GATE_CYCLES sys_clk cycles
// and reports the raw count. With GATE_CYCLES = sys_clk frequency in kHz the
// result reads directly in kHz.
// Ports:
//   sys_clk     in   reference clock; all control and outputs live here
//   sys_rst_n   in   asynchronous active-low reset
//   clk_test    in   clock under measurement (may be absent or stopped)
//   pll_lock    in   PLL lock, asynchronous
//   meas_en     in   continuous-measurement enable (level)
//   freq_cnt    out  last valid edge count (0 on error)
//   freq_valid  out  one-cycle pulse when freq_cnt / meas_err update
//   meas_err    out  1 = timeout or lock loss; held until next freq_valid
//   busy        out  high whenever the controller is not idle
// ----------------------------------------------------------------------------
module clk_freq_meter
   import clk_freq_meter_pkg::*;
#(
   parameter int GATE_CYCLES    = GATE_1MS,
   parameter int CNT_W          = 20,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             clk_test,
   input  logic             pll_lock,
   input  logic             meas_en,
   output logic [CNT_W-1:0] freq_cnt,
   output logic             freq_valid,
   output logic             meas_err,
   output logic             busy
);

   // One counter serves both the gate window and the done timeout.
   localparam int TMR_W = $clog2(max_int(GATE_CYCLES, TIMEOUT_CYCLES));
   localparam logic [TMR_W-1:0] GATE_LAST = TMR_W'(GATE_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

   // ------------------------------------------------------------------------
   // sys_clk domain
   // ------------------------------------------------------------------------
   state_t           state_reg, state_next;
   logic [TMR_W-1:0] tmr_reg, tmr_next;
   logic             err_pend_reg, err_pend_next;
   logic             done_seen_reg;
   logic             gate_reg;
   logic             lock_s, done_tgl_s, done_edge;
   logic             load_result, load_drain;

   // clk_test-domain signals referenced by the sys side
   logic             done_tgl_reg;
   logic [CNT_W-1:0] hold_reg;

   cdc_sync2 #(.W(1)) u_lock_sync (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .d     (pll_lock),
      .q     (lock_s)
   );

   cdc_sync2 #(.W(1)) u_done_sync (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .d     (done_tgl_reg),
      .q     (done_tgl_s)
   );

   // done_seen_reg follows done_tgl_s in every state, so a toggle that lands
   // while idle or gating is absorbed and never mistaken for a later result.
   assign done_edge = done_tgl_s ^ done_seen_reg;

   always_comb begin
      state_next    = state_reg;
      tmr_next      = tmr_reg + 1'b1;
      err_pend_next = err_pend_reg;
      load_result   = 1'b0;
      load_drain    = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            tmr_next = '0;
            if (meas_en && lock_s) begin
               state_next    = ST_GATE;
               err_pend_next = 1'b0;
            end
         end
         ST_GATE: begin
            if (!lock_s) begin
               state_next    = ST_DRAIN;
               err_pend_next = 1'b1;
               tmr_next      = '0;
            end else if (tmr_reg == GATE_LAST) begin
               state_next = ST_WAIT_DONE;
               tmr_next   = '0;
            end
         end
         ST_WAIT_DONE: begin
            if (done_edge) begin
               state_next = ST_REPORT;
            end else if (tmr_reg == TMO_LAST) begin
               state_next    = ST_REPORT;
               err_pend_next = 1'b1;
            end
         end
         ST_REPORT: begin
            load_result = 1'b1;
            tmr_next    = '0;
            if (meas_en && lock_s) begin
               state_next    = ST_GATE;
               err_pend_next = 1'b0;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            // Wait for the aborted window to close on the test side so its
            // toggle cannot leak into the next measurement.
            if (done_edge || (tmr_reg == TMO_LAST)) begin
               load_drain = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_reg     <= ST_IDLE;
         tmr_reg       <= '0;
         err_pend_reg  <= 1'b0;
         done_seen_reg <= 1'b0;
         gate_reg      <= 1'b0;
         freq_cnt      <= '0;
         freq_valid    <= 1'b0;
         meas_err      <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state_reg     <= state_next;
         tmr_reg       <= tmr_next;
         err_pend_reg  <= err_pend_next;
         done_seen_reg <= done_tgl_s;
         // Registered so the signal crossing into clk_test is glitch-free.
         gate_reg      <= (state_next == ST_GATE);
         busy          <= (state_next != ST_IDLE);
         freq_valid    <= load_result | load_drain;
         if (load_result) begin
            // hold_reg was written before the toggle we just saw, so it is
            // stable here despite belonging to the clk_test domain.
            freq_cnt <= err_pend_reg ? '0 : hold_reg;
            meas_err <= err_pend_reg;
         end else if (load_drain) begin
            freq_cnt <= '0;
            meas_err <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // clk_test domain
   // ------------------------------------------------------------------------
   logic             rst_t_n;
   logic             gate_t, gate_d_reg;
   logic [CNT_W-1:0] cnt_reg;

   // Reset asserts immediately, releases after two clk_test edges.
   cdc_sync2 #(.W(1)) u_rst_sync (
      .clk   (clk_test),
      .rst_n (sys_rst_n),
      .d     (1'b1),
      .q     (rst_t_n)
   );

   cdc_sync2 #(.W(1)) u_gate_sync (
      .clk   (clk_test),
      .rst_n (rst_t_n),
      .d     (gate_reg),
      .q     (gate_t)
   );

   always_ff @(posedge clk_test or negedge rst_t_n) begin
      if (!rst_t_n) begin
         gate_d_reg   <= 1'b0;
         cnt_reg      <= '0;
         hold_reg     <= '0;
         done_tgl_reg <= 1'b0;
      end else begin
         gate_d_reg <= gate_t;
         if (gate_t && !gate_d_reg) begin
            cnt_reg <= '0;
         end else if (gate_t && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + 1'b1;
         end
         if (!gate_t && gate_d_reg) begin
            hold_reg     <= cnt_reg;
            done_tgl_reg <= ~done_tgl_reg;
         end
      end
   end

endmodule

// File: tb/tb_clk_freq_meter.sv
`timescale 1ns/1ps
module tb_clk_freq_meter;

   localparam int G  = 1000;
   localparam int T  = 1024;
   localparam int W  = 20;
   localparam int TOL = 2;

   logic         sys_clk   = 1'b0;
   logic         sys_rst_n = 1'b0;
   logic         clk_test  = 1'b0;
   logic         pll_lock  = 1'b0;
   logic         meas_en   = 1'b0;
   logic [W-1:0] freq_cnt;
   logic         freq_valid;
   logic         meas_err;
   logic         busy;

   bit tclk_en = 1'b1;
   int t_half  = 5;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      int half_ns;
      int exp_cnt;
      int gap_max;
   } vec_t;

   vec_t vecs [5];

   clk_freq_meter #(
      .GATE_CYCLES    (G),
      .CNT_W          (W),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .clk_test   (clk_test),
      .pll_lock   (pll_lock),
      .meas_en    (meas_en),
      .freq_cnt   (freq_cnt),
      .freq_valid (freq_valid),
      .meas_err   (meas_err),
      .busy       (busy)
   );

   // 50 MHz reference
   always #10 sys_clk = ~sys_clk;

   // Test clock: offset by 0.3 ns so its edges never coincide with sys_clk.
   initial begin
      #0.3;
      forever begin
         if (tclk_en) begin
            #(t_half) clk_test = ~clk_test;
         end else begin
            clk_test = 1'b0;
            #1;
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input longint act, input longint lo, input longint hi);
      n_tests++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
      end else begin
         $display("[TB] ok   %s: %0d", name, act);
      end
   endtask

   task automatic wait_valid(input string name, output int cycles);
      cycles = 0;
      do begin
         @(posedge sys_clk);
         #1;
         cycles++;
      end while (!freq_valid && cycles < 3000);
      if (!freq_valid) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: no freq_valid within %0d cycles", name, cycles);
      end
   endtask

   task automatic count_valids(input int ncyc, output int nv);
      nv = 0;
      repeat (ncyc) begin
         @(posedge sys_clk);
         #1;
         if (freq_valid) nv++;
      end
   endtask

   initial begin
      int cyc;
      int nv;

      vecs[0] = '{half_ns: 5,   exp_cnt: 2000, gap_max: 1010};
      vecs[1] = '{half_ns: 500, exp_cnt: 20,   gap_max: 1200};
      vecs[2] = '{half_ns: 20,  exp_cnt: 500,  gap_max: 1012};
      vecs[3] = '{half_ns: 10,  exp_cnt: 1000, gap_max: 1010};
      vecs[4] = '{half_ns: 5,   exp_cnt: 2000, gap_max: 1010};

      // Reset state
      repeat (3) @(posedge sys_clk);
      #1;
      check("rst freq_cnt",   freq_cnt,   0, 0);
      check("rst freq_valid", freq_valid, 0, 0);
      check("rst meas_err",   meas_err,   0, 0);
      check("rst busy",       busy,       0, 0);

      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      pll_lock  = 1'b1;
      meas_en   = 1'b1;

      wait_valid("first", cyc);
      check("first cnt",  freq_cnt, 2000 - TOL, 2000 + TOL);
      check("first err",  meas_err, 0, 0);
      check("first busy", busy,     1, 1);

      // Frequency table; first window after a switch is discarded
      for (int i = 0; i < 5; i++) begin
         t_half = vecs[i].half_ns;
         wait_valid($sformatf("v%0d discard", i), cyc);
         wait_valid($sformatf("v%0d", i), cyc);
         check($sformatf("v%0d cnt", i), freq_cnt, vecs[i].exp_cnt - TOL, vecs[i].exp_cnt + TOL);
         check($sformatf("v%0d err", i), meas_err, 0, 0);
         check($sformatf("v%0d gap", i), cyc, G + 3, vecs[i].gap_max);
      end

      // Absent clk_test: stop right at GATE entry
      wait_valid("pre-stop", cyc);
      tclk_en = 1'b0;
      wait_valid("stopped", cyc);
      check("stop gap", cyc, G + T + 1, G + T + 1);
      check("stop cnt", freq_cnt, 0, 0);
      check("stop err", meas_err, 1, 1);
      repeat (5) @(posedge sys_clk);
      #1;
      check("err sticky", meas_err, 1, 1);
      tclk_en = 1'b1;
      wait_valid("restart discard", cyc);
      wait_valid("restart", cyc);
      check("restart cnt", freq_cnt, 2000 - TOL, 2000 + TOL);
      check("restart err", meas_err, 0, 0);

      // Lock loss 300 cycles into GATE
      repeat (300) @(posedge sys_clk);
      #1;
      pll_lock = 1'b0;
      wait_valid("lock drop", cyc);
      check("lock cnt",     freq_cnt, 0, 0);
      check("lock err",     meas_err, 1, 1);
      check("lock latency", cyc, 3, 20);
      repeat (3) @(posedge sys_clk);
      #1;
      check("lock busy", busy, 0, 0);
      count_valids(2500, nv);
      check("lock no valid", nv, 0, 0);
      check("lock busy late", busy, 0, 0);
      pll_lock = 1'b1;
      wait_valid("relock", cyc);
      check("relock cnt", freq_cnt, 2000 - TOL, 2000 + TOL);
      check("relock err", meas_err, 0, 0);

      // meas_en dropped mid-window
      repeat (200) @(posedge sys_clk);
      #1;
      meas_en = 1'b0;
      wait_valid("en drop", cyc);
      check("en cnt", freq_cnt, 2000 - TOL, 2000 + TOL);
      check("en err", meas_err, 0, 0);
      repeat (3) @(posedge sys_clk);
      #1;
      check("en busy", busy, 0, 0);
      count_valids(3000, nv);
      check("en no valid", nv, 0, 0);

      // Reset mid-window
      meas_en = 1'b1;
      wait_valid("re-en", cyc);
      check("re-en cnt", freq_cnt, 2000 - TOL, 2000 + TOL);
      repeat (400) @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b0;
      #1;
      check("mid rst freq_cnt",   freq_cnt,   0, 0);
      check("mid rst freq_valid", freq_valid, 0, 0);
      check("mid rst meas_err",   meas_err,   0, 0);
      check("mid rst busy",       busy,       0, 0);
      repeat (5) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      wait_valid("post-reset", cyc);
      check("post-reset cnt", freq_cnt, 2000 - TOL, 2000 + TOL);
      check("post-reset err", meas_err, 0, 0);
      check("post-reset gap", cyc, G + 3, G + 12);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/clk_freq_meter.md
# clk_freq_meter

Gated-window frequency meter for the PLL output clocks. It counts rising edges of one test clock, clk_test, over a fixed window of sys_clk cycles and reports the raw count. The input is one PLL output, or the output of the board-level PLL clock selector. The block sits directly downstream of the PLL and provides self-check of clkout0..clkout3 (1/25/50/100 MHz) in bring-up and test benches. With GATE_CYCLES = sys_clk frequency in kHz (50000 at 50 MHz), the count reads directly in kHz.

## Interface
- GATE_CYCLES, 50000: gate window length in sys_clk cycles (≥ 16).
- CNT_W, 20: width of the test-clock counter and the result.
- TIMEOUT_CYCLES, 1024: sys_clk cycles to wait for the done handshake after the gate closes.
- sys_clk  in  1  reference clock; all control and outputs are in this domain.
- sys_rst_n  in  1  asynchronous, active-low reset.
- clk_test  in  1  clock under measurement; may be absent or stopped.
- pll_lock  in  1  PLL lock, asynchronous; synchronized internally with 2 FF.
- meas_en  in  1  continuous-measurement enable, level.
- freq_cnt  out  CNT_W  last valid edge count.
- freq_valid  out  1  one-cycle pulse when freq_cnt or meas_err updates.
- meas_err  out  1  sticky until the next freq_valid; 1 = timeout or lock loss.
- busy  out  1  high in every state except IDLE.

## Operation
sys_clk FSM states: IDLE, GATE, WAIT_DONE, REPORT, DRAIN.
- IDLE: gate=0. When meas_en and lock_s are both 1 → GATE, and clear the window counter.
- GATE: gate=1 for exactly GATE_CYCLES cycles, then → WAIT_DONE. lock_s falling → DRAIN with err_pend=1.
- WAIT_DONE: gate=0. On edge of done_tgl_s → REPORT. If TIMEOUT_CYCLES elapse first → REPORT with count forced to 0 and err_pend=1.
- REPORT (1 cycle): load freq_cnt, set meas_err=err_pend, pulse freq_valid. Then → GATE if meas_en and lock_s, else → IDLE.
- DRAIN: gate=0. Wait for a done_tgl_s edge or a timeout, and discard the result. Then pulse freq_valid with freq_cnt=0 and meas_err=1, then → IDLE.

clk_test domain:
- Reset is sys_rst_n, asserted asynchronously and deasserted synchronously to clk_test (2 FF).
- gate is synchronized with 2 FF to gate_t.
- gate_t rising: clear cnt to 0.
- While gate_t is high: cnt += 1 per edge, saturating at all-ones.
- gate_t falling: copy cnt to hold_reg and toggle done_tgl.

Back in the sys_clk domain:
- done_tgl is synchronized with 2 FF to done_tgl_s.
- hold_reg is sampled only in REPORT. It is stable by construction: it is written once, before the toggle.

Boundary rules:
- meas_en deasserting mid-window does not abort. The current measurement completes, then the FSM → IDLE.
- A stale toggle arriving in IDLE or GATE is ignored. The sys side tracks the last-seen toggle level, and that level is updated in every state.
- Reset mid-window puts both domains at their reset values. No freq_valid is issued for the aborted window.

## Timing
- Reset values: freq_cnt=0, freq_valid=0, meas_err=0, busy=0. Internally, gate=0, cnt=0, hold_reg=0, done_tgl=0.
- Measurement cycle from GATE entry to freq_valid is GATE_CYCLES + ~2 clk_test + 3..4 sys_clk cycles. Back-to-back windows add 1 cycle (REPORT).
- Accuracy is ±2 counts, from gate synchronizer phase uncertainty at the open and close edges.
- Absent clk_test: freq_valid comes exactly GATE_CYCLES + TIMEOUT_CYCLES + 1 cycles after GATE entry, with freq_cnt=0 and meas_err=1.

## Structure
- Shared package holds:
  - the FSM state encoding (3-bit localparams ST_IDLE..ST_DRAIN)
  - the default gate constant for a 50 MHz sys_clk (GATE_1MS = 50000).
- One sub-module, cdc_sync2: a parameterizable-width 2-FF synchronizer. It is instanced for pll_lock, gate, done_tgl and the clk_test reset release.
- The clk_test-domain counter stays inline in clk_freq_meter.

## Test plan
- sys_clk 50 MHz, GATE_CYCLES=1000, clk_test 100 MHz, meas_en=1, lock=1 → freq_valid every ~1005 cycles, freq_cnt=2000±2, meas_err=0.
- Same setup, clk_test at 1, 25 and 50 MHz, switched between windows → 20±2, 500±2, 1000±2. The first window after a switch may be discarded.
- clk_test held low → freq_valid at cycle 1000+1024+1 after GATE entry, freq_cnt=0, meas_err=1. Restarting the clock → next window is correct and meas_err is cleared.
- pll_lock dropped 300 cycles into GATE → DRAIN, one freq_valid with freq_cnt=0 and meas_err=1, then IDLE with busy=0 while lock=0.
- meas_en dropped mid-window → the window completes with a correct count, then IDLE. No further freq_valid.
- sys_rst_n asserted mid-window → all outputs 0 immediately. After release plus enable, the first result is correct with no stale toggle report.
